// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline/CP0 signal bundle for the exception controller
//
// Purpose: groups every signal of cp0_exc_ctrl except clk/rst_n.
// Modports:
//   master - pipeline/CP0 side: drives status, interrupt, commit and ack inputs,
//            receives int_req, exception, exc_code, eret_flush, cause_ip_hw.
//   slave  - the exception controller itself.
// Optional timer signals (count_we, compare_we, cp0_wdata, count) exist only
// when CP0_TIMER_INT_EN is defined.
interface cp0_exc_ctrl_if;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  hw_int;
  logic        wb_exc_valid;
  logic [4:0]  wb_exc_code;
  logic        wb_eret;
  logic        exc_ack;
  logic        int_req;
  logic        exception;
  logic [4:0]  exc_code;
  logic        eret_flush;
  logic [5:0]  cause_ip_hw;
`ifdef CP0_TIMER_INT_EN
  logic        count_we;
  logic        compare_we;
  logic [31:0] cp0_wdata;
  logic [31:0] count;
`endif

  modport master (
`ifdef CP0_TIMER_INT_EN
    output count_we, compare_we, cp0_wdata, input count,
`endif
    output status_ie, status_exl, status_im, cause_ip_sw, hw_int,
    output wb_exc_valid, wb_exc_code, wb_eret, exc_ack,
    input  int_req, exception, exc_code, eret_flush, cause_ip_hw
  );

  modport slave (
`ifdef CP0_TIMER_INT_EN
    input count_we, compare_we, cp0_wdata, output count,
`endif
    input  status_ie, status_exl, status_im, cause_ip_sw, hw_int,
    input  wb_exc_valid, wb_exc_code, wb_eret, exc_ack,
    output int_req, exception, exc_code, eret_flush, cause_ip_hw
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt entry sequencer
//
// Purpose: synchronizes external interrupt lines, evaluates the pending
// interrupt condition, and sequences exception entry / ERET pulses to CP0.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - cp0_exc_ctrl_if.slave: status/cause inputs, hw_int, commit-stage
//           exception/ERET, exc_ack; outputs int_req, exception, exc_code,
//           eret_flush, cause_ip_hw.
// Optional feature macro: CP0_TIMER_INT_EN adds Count/Compare and a timer
// interrupt ORed into cause_ip_hw[5].
module cp0_exc_ctrl (
  input logic           clk,
  input logic           rst_n,
  cp0_exc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FLUSH = 3'd2,
    S_HOLD  = 3'd3,
    S_ERET  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_next_code;
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [5:0] w_cause_ip_hw;
  logic       w_int_pending;
  logic       r_int_req;
  logic       r_exception;
  logic [4:0] r_exc_code;
  logic       r_eret_flush;

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 6'h00;
      r_sync2 <= 6'h00;
    end else begin
      r_sync1 <= bus.hw_int;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_int;
  logic        r_half;

  // Count advances on every second clock; a software write overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 32'h0;
      r_compare   <= 32'h0;
      r_timer_int <= 1'b0;
      r_half      <= 1'b0;
    end else begin
      r_half <= ~r_half;
      if (bus.count_we) begin
        r_count <= bus.cp0_wdata;
      end else if (r_half) begin
        r_count <= r_count + 32'd1;
      end
      if (bus.compare_we) begin
        r_compare <= bus.cp0_wdata;
      end
      // Writing Compare acknowledges the timer interrupt.
      if (bus.compare_we) begin
        r_timer_int <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign bus.count     = r_count;
  assign w_cause_ip_hw = {r_sync2[5] | r_timer_int, r_sync2[4:0]};
`else
  assign w_cause_ip_hw = r_sync2;
`endif

  assign bus.cause_ip_hw = w_cause_ip_hw;
  assign w_int_pending   = bus.status_ie & ~bus.status_exl &
                           (|({w_cause_ip_hw, bus.cause_ip_sw} & bus.status_im));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Synchronous exceptions outrank ERET and interrupts; HOLD blocks all new
  // entries until software has raised EXL.
  always_comb begin
    w_next      = r_state;
    w_next_code = 5'h00;
    case (r_state)
      S_IDLE: begin
        if (bus.wb_exc_valid) begin
          w_next      = S_FLUSH;
          w_next_code = bus.wb_exc_code;
        end else if (bus.wb_eret) begin
          w_next = S_ERET;
        end else if (w_int_pending) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.wb_exc_valid) begin
          w_next      = S_FLUSH;
          w_next_code = bus.wb_exc_code;
        end else if (bus.exc_ack) begin
          w_next = S_FLUSH;
        end else if (!w_int_pending) begin
          w_next = S_IDLE;
        end
      end
      S_FLUSH: w_next = S_HOLD;
      S_HOLD:  if (bus.status_exl) w_next = S_IDLE;
      S_ERET:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_req    <= 1'b0;
      r_exception  <= 1'b0;
      r_exc_code   <= 5'h00;
      r_eret_flush <= 1'b0;
    end else begin
      r_int_req    <= (w_next == S_REQ);
      r_exception  <= (w_next == S_FLUSH);
      r_exc_code   <= (w_next == S_FLUSH) ? w_next_code : 5'h00;
      r_eret_flush <= (w_next == S_ERET);
    end
  end

  assign bus.int_req    = r_int_req;
  assign bus.exception  = r_exception;
  assign bus.exc_code   = r_exc_code;
  assign bus.eret_flush = r_eret_flush;

endmodule
